program_memory_arbiter: RTL and testbench

PROGRAM_MEMORY_ARBITER -- requirements
Module: program_memory_arbiter

---
 rtl/program_memory_arbiter_pkg.sv | 10 +
 rtl/program_memory_arbiter_if.sv | 24 ++
 rtl/program_memory_arbiter_pipeline.sv | 19 +
 rtl/program_memory_arbiter.sv | 71 +++++++
 tb/tb_program_memory_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/program_memory_arbiter_pkg.sv
// pmem_arb_pkg: shared types and constants for program_memory_arbiter.
package pmem_arb_pkg;
  localparam int NUM_REQ = 2;
  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
  typedef enum logic {WAIT_READY, ACTIVE} state_t;
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/program_memory_arbiter_if.sv
// program_memory_arbiter_if: requester and program-memory bus signals; master = arbiter, slave = environment.
interface program_memory_arbiter_if #(parameter int ADDR_W = 32);
  logic              mem_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic              req0_read_request, req1_read_request;
  logic              req0_grant, req1_grant;
  logic [31:0]       req0_instr, req1_instr;
  logic              req0_data_valid, req1_data_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_request;
  logic [31:0]       mem_instr;
  logic              mem_data_valid;
  logic              protocol_err;
  modport master (
    input  mem_ready, req0_addr, req1_addr, req0_read_request, req1_read_request, mem_instr, mem_data_valid,
    output req0_grant, req1_grant, req0_instr, req1_instr, req0_data_valid, req1_data_valid,
           mem_addr, mem_read_request, protocol_err
  );
  modport slave (
    output mem_ready, req0_addr, req1_addr, req0_read_request, req1_read_request, mem_instr, mem_data_valid,
    input  req0_grant, req1_grant, req0_instr, req1_instr, req0_data_valid, req1_data_valid,
           mem_addr, mem_read_request, protocol_err
  );
endinterface

// File: rtl/program_memory_arbiter_pipeline.sv
// program_memory_arbiter_pipeline: STAGES-deep register delay line with async reset.
module program_memory_arbiter_pipeline #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r [STAGES];
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) for (int i = 0; i < STAGES; i++) r[i] <= '0;
    else begin
      r[0] <= d;
      for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
    end
  assign q = r[STAGES-1];
endmodule

// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: two-requester read arbiter for program memory with tagged return routing.
// Define PMEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to requester 0.
module program_memory_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 32
) (
  input logic                     clk_in,
  input logic                     rst_in,
  program_memory_arbiter_if.master bus
);
  state_t             state, state_next;
  logic [NUM_REQ-1:0] grant, elig;
  logic               active, issue, mem_read_request, protocol_err;
  req_id_t            pick, issue_id;
  logic [ADDR_W-1:0]  mem_addr;
  tag_t               tag_in, tag_out;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= WAIT_READY;
    else state <= state_next;
  always_comb state_next = bus.mem_ready ? ACTIVE : WAIT_READY;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  req_id_t last;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) last <= req_id_t'(1);
    else if (issue) last <= pick;
`endif
  // A requester already holding a grant this cycle is masked so its held request is not issued twice.
  always_comb begin
    active = state == ACTIVE;
    elig   = active ? {bus.req1_read_request, bus.req0_read_request} & ~grant : '0;
    issue  = |elig;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    pick   = &elig ? ~last : elig[1];
`else
    pick   = ~elig[0];
`endif
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      grant            <= '0;
      mem_read_request <= 1'b0;
      mem_addr         <= '0;
      issue_id         <= '0;
    end else begin
      grant            <= {issue & pick, issue & ~pick};
      mem_read_request <= issue;
      mem_addr         <= issue ? (pick ? bus.req1_addr : bus.req0_addr) : mem_addr;
      issue_id         <= pick;
    end
  assign tag_in = '{valid: mem_read_request, id: issue_id};
  program_memory_arbiter_pipeline #(.WIDTH($bits(tag_t)), .STAGES(READ_LATENCY)) u_tag_pipe (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .d     (tag_in),
    .q     (tag_out)
  );
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) protocol_err <= 1'b0;
    else if (tag_out.valid && !bus.mem_data_valid) protocol_err <= 1'b1;
  assign bus.req0_grant       = grant[0];
  assign bus.req1_grant       = grant[1];
  assign bus.mem_read_request = mem_read_request;
  assign bus.mem_addr         = mem_addr;
  assign bus.req0_instr       = bus.mem_instr;
  assign bus.req1_instr       = bus.mem_instr;
  assign bus.req0_data_valid  = bus.mem_data_valid & tag_out.valid & (tag_out.id == req_id_t'(0));
  assign bus.req1_data_valid  = bus.mem_data_valid & tag_out.valid & (tag_out.id == req_id_t'(1));
  assign bus.protocol_err     = protocol_err;
endmodule

// File: tb/tb_program_memory_arbiter.sv
// tb_program_memory_arbiter: scoreboard bench with a fixed-latency memory model and per-scenario tasks.
module tb_program_memory_arbiter;
  localparam int LAT = 2;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        suppress = 1'b0;
  logic        s0_v;
  logic [31:0] s0_d;
  logic [32:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  always #5 clk_in = ~clk_in;
  program_memory_arbiter_if #(.ADDR_W(32)) ifc ();
  program_memory_arbiter #(.READ_LATENCY(LAT), .ADDR_W(32)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (ifc)
  );
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction
  // Two-stage memory model (LAT=2); not reset so late returns survive a DUT reset.
  always @(posedge clk_in) begin
    s0_v               <= ifc.mem_read_request & ~suppress;
    s0_d               <= mem_fn(ifc.mem_addr);
    ifc.mem_data_valid <= s0_v;
    ifc.mem_instr      <= s0_d;
  end
  always @(negedge clk_in) begin
    logic        id;
    logic [31:0] a;
    logic [32:0] e;
    if (!rst_in) begin
      if (ifc.req0_grant | ifc.req1_grant) begin
        id = ifc.req1_grant;
        a  = id ? ifc.req1_addr : ifc.req0_addr;
        checks++;
        if (ifc.req0_grant & ifc.req1_grant) begin errors++; $display("FAIL sb_two_grants got 11 want one-hot"); end
        checks++;
        if (ifc.mem_addr !== a) begin errors++; $display("FAIL sb_mem_addr got %h want %h", ifc.mem_addr, a); end
        exp_q.push_back({id, mem_fn(a)});
      end
      if (ifc.req0_data_valid | ifc.req1_data_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_unexpected_return got dv=%b%b want none", ifc.req1_data_valid, ifc.req0_data_valid);
        end else begin
          e = exp_q.pop_front();
          if ({ifc.req1_data_valid, ifc.req0_data_valid} !== (e[32] ? 2'b10 : 2'b01) || ifc.req0_instr !== e[31:0] || ifc.req1_instr !== e[31:0]) begin
            errors++;
            $display("FAIL sb_return got dv=%b%b instr=%h want id=%0d instr=%h", ifc.req1_data_valid, ifc.req0_data_valid, ifc.req0_instr, e[32], e[31:0]);
          end
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic test_reset();
    ifc.mem_ready = 1'b1; ifc.req0_read_request = 1'b1; ifc.req1_read_request = 1'b1;
    ifc.req0_addr = 32'h44; ifc.req1_addr = 32'h88;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checks++;
      if ({ifc.req1_grant, ifc.req0_grant, ifc.mem_read_request} !== 3'b000) begin
        errors++; $display("FAIL reset_grants got %b want 000", {ifc.req1_grant, ifc.req0_grant, ifc.mem_read_request});
      end
      checks++;
      if (ifc.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", ifc.mem_addr); end
      checks++;
      if ({ifc.req1_data_valid, ifc.req0_data_valid, ifc.protocol_err} !== 3'b000) begin
        errors++; $display("FAIL reset_flags got %b want 000", {ifc.req1_data_valid, ifc.req0_data_valid, ifc.protocol_err});
      end
    end
    ifc.req0_read_request = 1'b0; ifc.req1_read_request = 1'b0; rst_in = 1'b0;
    step(3);
  endtask
  task automatic test_single();
    ifc.req0_addr = 32'h40; ifc.req0_read_request = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant, ifc.mem_read_request} !== 3'b011) begin
      errors++; $display("FAIL single_grant got %b want 011", {ifc.req1_grant, ifc.req0_grant, ifc.mem_read_request});
    end
    ifc.req0_read_request = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant, ifc.req0_data_valid} !== 3'b000) begin
      errors++; $display("FAIL single_pulse got %b want 000", {ifc.req1_grant, ifc.req0_grant, ifc.req0_data_valid});
    end
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_data_valid, ifc.req0_data_valid} !== 2'b01 || ifc.req0_instr !== mem_fn(32'h40)) begin
      errors++; $display("FAIL single_return got dv=%b%b instr=%h want 01 %h", ifc.req1_data_valid, ifc.req0_data_valid, ifc.req0_instr, mem_fn(32'h40));
    end
    @(negedge clk_in);
    checks++;
    if (ifc.req0_data_valid !== 1'b0) begin errors++; $display("FAIL single_dv_drop got 1 want 0"); end
    step(2);
  endtask
  task automatic test_contention();
    ifc.req0_addr = 32'h100; ifc.req1_addr = 32'h200;
    ifc.req0_read_request = 1'b1; ifc.req1_read_request = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      checks++;
      if ({ifc.req1_grant, ifc.req0_grant} !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL contention_grant[%0d] got %b want %b", i, {ifc.req1_grant, ifc.req0_grant}, (i % 2 == 0 ? 2'b01 : 2'b10));
      end
    end
    ifc.req0_read_request = 1'b0; ifc.req1_read_request = 1'b0;
    step(4);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL contention_drain got %0d pending want 0", exp_q.size()); end
  endtask
  task automatic test_priority();
    logic [1:0] want;
    ifc.req0_addr = 32'h300; ifc.req1_addr = 32'h304; ifc.req0_read_request = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant} !== 2'b01) begin errors++; $display("FAIL prio_solo got %b want 01", {ifc.req1_grant, ifc.req0_grant}); end
    ifc.req0_read_request = 1'b0;
    @(negedge clk_in);
    ifc.req0_read_request = 1'b1; ifc.req1_read_request = 1'b1;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    want = 2'b10;
`else
    want = 2'b01;
`endif
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant} !== want) begin errors++; $display("FAIL prio_winner got %b want %b", {ifc.req1_grant, ifc.req0_grant}, want); end
    if (want[0]) ifc.req0_read_request = 1'b0; else ifc.req1_read_request = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant} !== ~want) begin errors++; $display("FAIL prio_loser got %b want %b", {ifc.req1_grant, ifc.req0_grant}, ~want); end
    ifc.req0_read_request = 1'b0; ifc.req1_read_request = 1'b0;
    step(4);
  endtask
  task automatic test_ready_gating();
    ifc.req0_addr = 32'h500; ifc.req0_read_request = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant} !== 2'b01) begin errors++; $display("FAIL gate_pre_grant got %b want 01", {ifc.req1_grant, ifc.req0_grant}); end
    ifc.req0_read_request = 1'b0; ifc.mem_ready = 1'b0;
    step(2);
    checks++;
    if (ifc.req0_data_valid !== 1'b1) begin errors++; $display("FAIL gate_outstanding_return got 0 want 1"); end
    step(1);
    ifc.req0_read_request = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      checks++;
      if ({ifc.req1_grant, ifc.req0_grant, ifc.mem_read_request} !== 3'b000) begin
        errors++; $display("FAIL gate_blocked[%0d] got %b want 000", i, {ifc.req1_grant, ifc.req0_grant, ifc.mem_read_request});
      end
    end
    ifc.mem_ready = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant} !== 2'b00) begin errors++; $display("FAIL gate_early got %b want 00", {ifc.req1_grant, ifc.req0_grant}); end
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant} !== 2'b01) begin errors++; $display("FAIL gate_first_grant got %b want 01", {ifc.req1_grant, ifc.req0_grant}); end
    ifc.req0_read_request = 1'b0;
    step(4);
  endtask
  task automatic test_reset_midflight();
    ifc.req1_addr = 32'h80; ifc.req1_read_request = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant} !== 2'b10) begin errors++; $display("FAIL midflight_grant got %b want 10", {ifc.req1_grant, ifc.req0_grant}); end
    ifc.req1_read_request = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_data_valid, ifc.req0_data_valid, ifc.protocol_err} !== 3'b000) begin
      errors++; $display("FAIL midflight_late_return got %b want 000", {ifc.req1_data_valid, ifc.req0_data_valid, ifc.protocol_err});
    end
    rst_in = 1'b0;
    exp_q.delete();
    @(negedge clk_in);
    checks++;
    if (ifc.protocol_err !== 1'b0) begin errors++; $display("FAIL midflight_err got 1 want 0"); end
    step(3);
  endtask
  task automatic test_missing_return();
    ifc.req0_addr = 32'h600; ifc.req0_read_request = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ifc.req1_grant, ifc.req0_grant} !== 2'b01) begin errors++; $display("FAIL missing_grant got %b want 01", {ifc.req1_grant, ifc.req0_grant}); end
    ifc.req0_read_request = 1'b0; suppress = 1'b1;
    @(negedge clk_in);
    suppress = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({ifc.req0_data_valid, ifc.protocol_err} !== 2'b00) begin
      errors++; $display("FAIL missing_early got %b want 00", {ifc.req0_data_valid, ifc.protocol_err});
    end
    @(negedge clk_in);
    checks++;
    if (ifc.protocol_err !== 1'b1) begin errors++; $display("FAIL missing_err_set got 0 want 1"); end
    step(4);
    checks++;
    if (ifc.protocol_err !== 1'b1) begin errors++; $display("FAIL missing_err_sticky got 0 want 1"); end
    exp_q.delete();
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (ifc.protocol_err !== 1'b0) begin errors++; $display("FAIL missing_err_reset got 1 want 0"); end
    rst_in = 1'b0;
    step(3);
  endtask
  initial begin
    ifc.mem_ready = 1'b0; ifc.req0_addr = '0; ifc.req1_addr = '0;
    ifc.req0_read_request = 1'b0; ifc.req1_read_request = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_priority();
    test_ready_gating();
    test_reset_midflight();
    test_missing_return();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
